cpu_checker1: RTL and testbench

CPU_CHECKER1 -- requirements
Module: cpu_checker1

---
 rtl/cpu_checker_pkg.sv | 11 +
 rtl/cpu_checker_char_class.sv | 18 +
 rtl/cpu_checker1.sv | 116 +++++++++++
 tb/tb_cpu_checker1.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_checker_pkg.sv
// cpu_checker_pkg: shared parser state encoding, format codes and field-length limits
package cpu_checker_pkg;
    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON_SP, GRF, ADDR, SP_PRE, EQ, SP_POST, DATA, SP_END, ACCEPT
    } state_t;
    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;
    localparam logic [3:0] DEC_MAX  = 4'd4;
    localparam logic [3:0] HEX_LEN  = 4'd8;
endpackage

// File: rtl/cpu_checker_char_class.sv
// cpu_checker_char_class: combinational ASCII classification for the line parser.
// Uppercase A-F count as hex only when CPU_CHECKER_UPPER_HEX_EN is defined.
module cpu_checker_char_class (
    input  logic [7:0] ch,
    output logic       is_dec,
    output logic       is_hex,
    output logic       is_space
);
    logic is_lower_hex;
    assign is_dec       = (ch >= "0") && (ch <= "9");
    assign is_lower_hex = (ch >= "a") && (ch <= "f");
    assign is_space     = (ch == 8'h20);
`ifdef CPU_CHECKER_UPPER_HEX_EN
    assign is_hex = is_dec || is_lower_hex || ((ch >= "A") && (ch <= "F"));
`else
    assign is_hex = is_dec || is_lower_hex;
`endif
endmodule

// File: rtl/cpu_checker1.sv
// cpu_checker1: streaming parser for CPU trace lines; flags register writes (1)
// and memory writes (2) for one cycle after the terminating '#'.
module cpu_checker1
    import cpu_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_q, mem_d;
    logic [1:0] fmt_q, fmt_d;
    logic       is_dec, is_hex, is_space;

    cpu_checker_char_class u_class (
        .ch       (char),
        .is_dec   (is_dec),
        .is_hex   (is_hex),
        .is_space (is_space)
    );

    // Every field counts digits in cnt; any unmatched character falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        mem_d   = mem_q;
        if (char == "^") begin
            state_d = TIME;
        end else begin
            case (state_q)
                TIME: begin
                    if (is_dec && cnt_q < DEC_MAX) begin
                        state_d = TIME;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == "@" && cnt_q != 4'd0) begin
                        state_d = PC;
                    end
                end
                PC: begin
                    if (is_hex && cnt_q < HEX_LEN) begin
                        state_d = PC;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == ":" && cnt_q == HEX_LEN) begin
                        state_d = COLON_SP;
                    end
                end
                COLON_SP: begin
                    if (is_space) begin
                        state_d = COLON_SP;
                    end else if (char == "$") begin
                        state_d = GRF;
                        mem_d   = 1'b0;
                    end else if (char == "*") begin
                        state_d = ADDR;
                        mem_d   = 1'b1;
                    end
                end
                GRF: begin
                    if (is_dec && cnt_q < DEC_MAX) begin
                        state_d = GRF;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (cnt_q != 4'd0) begin
                        state_d = is_space ? SP_PRE : (char == "<") ? EQ : IDLE;
                    end
                end
                ADDR: begin
                    if (is_hex && cnt_q < HEX_LEN) begin
                        state_d = ADDR;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (cnt_q == HEX_LEN) begin
                        state_d = is_space ? SP_PRE : (char == "<") ? EQ : IDLE;
                    end
                end
                SP_PRE:  state_d = is_space ? SP_PRE : (char == "<") ? EQ : IDLE;
                EQ:      state_d = (char == "=") ? SP_POST : IDLE;
                SP_POST: begin
                    if (is_space) begin
                        state_d = SP_POST;
                    end else if (is_hex) begin
                        state_d = DATA;
                        cnt_d   = 4'd1;
                    end
                end
                DATA: begin
                    if (is_hex && cnt_q < HEX_LEN) begin
                        state_d = DATA;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (cnt_q == HEX_LEN) begin
                        state_d = is_space ? SP_END : (char == "#") ? ACCEPT : IDLE;
                    end
                end
                SP_END:  state_d = is_space ? SP_END : (char == "#") ? ACCEPT : IDLE;
                default: state_d = IDLE;
            endcase
        end
        fmt_d = (state_d == ACCEPT) ? (mem_q ? FMT_MEM : FMT_REG) : FMT_NONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mem_q   <= 1'b0;
            fmt_q   <= FMT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            fmt_q   <= fmt_d;
        end
    end

    assign format_type = fmt_q;
endmodule

// File: tb/tb_cpu_checker1.sv
// tb_cpu_checker1: scoreboard bench; a string-level grammar matcher predicts format_type per character.
module tb_cpu_checker1;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] char = 8'h00;
    logic [1:0] format_type;

    int  errors = 0;
    int  checks = 0;
    logic [1:0] exp_q[$];
    byte line[$];
    bit  active = 1'b0;
    string alph = "0123456789abcdefABCDEF@:$*<=# ^zx";

    cpu_checker1 dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type)
    );

    always #5 clk = ~clk;

    function automatic bit cls(input byte c, input int k);
        bit dec = (c >= "0" && c <= "9");
        bit hex = dec || (c >= "a" && c <= "f");
`ifdef CPU_CHECKER_UPPER_HEX_EN
        hex = hex || (c >= "A" && c <= "F");
`endif
        return (k == 0) ? dec : (k == 1) ? hex : (c == " ");
    endfunction

    function automatic byte at(input byte s[$], input int i);
        return (i < s.size()) ? s[i] : 8'h00;
    endfunction

    function automatic int run(input byte s[$], input int i, input int k);
        int n = 0;
        while (i + n < s.size() && cls(s[i + n], k)) n++;
        return n;
    endfunction

    // Whole-line match of the text following '^' (through the current '#').
    function automatic logic [1:0] model(input byte s[$]);
        int i = 0;
        int n;
        logic [1:0] kind;
        n = run(s, i, 0);
        if (n < 1 || n > 4) return 2'd0;
        i += n;
        if (at(s, i) != "@") return 2'd0;
        i++;
        if (run(s, i, 1) != 8) return 2'd0;
        i += 8;
        if (at(s, i) != ":") return 2'd0;
        i++;
        i += run(s, i, 2);
        if (at(s, i) == "$") begin
            kind = 2'd1;
            i++;
            n = run(s, i, 0);
            if (n < 1 || n > 4) return 2'd0;
            i += n;
        end else if (at(s, i) == "*") begin
            kind = 2'd2;
            i++;
            if (run(s, i, 1) != 8) return 2'd0;
            i += 8;
        end else begin
            return 2'd0;
        end
        i += run(s, i, 2);
        if (at(s, i) != "<") return 2'd0;
        i++;
        if (at(s, i) != "=") return 2'd0;
        i++;
        i += run(s, i, 2);
        if (run(s, i, 1) != 8) return 2'd0;
        i += 8;
        i += run(s, i, 2);
        if (at(s, i) != "#") return 2'd0;
        i++;
        return (i == s.size()) ? kind : 2'd0;
    endfunction

    task automatic send_char(input byte c);
        @(negedge clk);
        reset = 1'b1;
        char  = c;
        if (c == "^") begin
            active = 1'b1;
            line.delete();
            exp_q.push_back(2'd0);
        end else begin
            if (active) line.push_back(c);
            exp_q.push_back((c == "#" && active) ? model(line) : 2'd0);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset  = 1'b0;
            char   = 8'($urandom_range(32, 126));
            active = 1'b0;
            line.delete();
            exp_q.push_back(2'd0);
        end
    endtask

    function automatic string sp(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (format_type !== e) begin
                errors++;
                $display("FAIL fmt t=%0t char=0x%02h got=%0d exp=%0d", $time, char, format_type, e);
            end
        end
    end

    initial begin
        string ln, data, body;
        int r;
        do_reset(3);
        send_str("^242@000030f4: $31 <=12345678#");
        send_str("^242@000030f4: $31 <=123215#");
        send_str("^242@000030f4: $31 <=123456781234#");
        send_str("^242@000030f4: $31 <=#");
        send_str("^242@000030f4: $31 <=   ab123215 #");
        send_str("^242@000030f4: $31 <=   Ab123215 #");
        send_str("^338@00003130: *00000088 <= fffb528#");
        send_str("^338@00003130: *00000088 <= fffb5288#");
        send_str("^338@00003130: *00000088 <= Ffffb528#");
        send_str("^9999@00000000:$1234<=deadbeef#^12345@00000000:$1<=deadbeef#");
        send_str("^1@00000000:$12345<=deadbeef##^1@0000000:$1<=deadbeef#");
        send_str("^242@000030f4: $3");
        do_reset(2);
        send_str("1 <=12345678#");
        send_str("^242@000030f4: $31 <=12345678#");
        send_str("^242@0000^242@000030f4: $31 <=12345678#");
        send_str("^1@00000001:*00000002<=00000003#^2@00000001:$0<=00000003#");
        for (int it = 0; it < 200; it++) begin
            ln = {"^", $sformatf("%0d", $urandom_range(0, 9999)), "@", $sformatf("%08x", $urandom), ":", sp($urandom_range(0, 2))};
            if ($urandom_range(0, 1) == 1)
                body = {"*", $sformatf("%08x", $urandom)};
            else
                body = {"$", $sformatf("%0d", $urandom_range(0, 31))};
            data = $sformatf("%08x", $urandom);
            r = $urandom_range(0, 5);
            if (r == 1) data = data.substr(0, 6);
            if (r == 2) data = {data, "a"};
            ln = {ln, body, sp($urandom_range(0, 2)), "<=", sp($urandom_range(0, 2)), data, sp($urandom_range(0, 2)), "#"};
            if (r == 3) ln.putc($urandom_range(1, ln.len() - 1), alph[$urandom_range(0, alph.len() - 1)]);
            if (r == 4) begin
                int cut = $urandom_range(1, ln.len() - 1);
                send_str(ln.substr(0, cut - 1));
                do_reset($urandom_range(1, 2));
                send_str(ln.substr(cut, ln.len() - 1));
            end else begin
                send_str(ln);
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) send_char(alph[$urandom_range(0, alph.len() - 1)]);
        end
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
